// File: rtl/awmf_frame_sequencer.sv
// awmf_frame_sequencer
// Command-queue front end for the SPI bit engine. Frames arrive on a
// valid/ready stream and are buffered in a small FIFO. Each frame is launched
// with a one-cycle spi_start, the sequencer waits for spi_done, optionally
// returns the captured receive vector on a valid/ready response stream, and
// holds a minimum idle gap before the next launch.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   cmd_valid/ready/bits/len/readback   command stream into the FIFO
//   rsp_valid/ready/bits        response stream (captured spi_rx_bits)
//   spi_start/bit_count/tx_bits to SPI master
//   spi_rx_bits/busy/done       from SPI master
//   fifo_level, frames_done     status
//   err_len, err_timeout        one-cycle error pulses
//
// Build option: define SEQ_TIMEOUT_EN to add a WAIT_DONE watchdog of
// TIMEOUT_CYCLES clocks; without it err_timeout is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | wait for a queued command and an idle SPI master, then pop
// LOAD      | frame registers hold the popped command; length check
// START     | spi_start pulse
// WAIT_DONE | wait for spi_done (or watchdog when enabled)
// RESP      | response presented until rsp_ready
// GAP       | enforce chip-select idle gap (GAP_CYCLES+1 clocks here)
module awmf_frame_sequencer #(
   parameter int MAX_BITS       = 100,
   parameter int FIFO_DEPTH     = 4,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [MAX_BITS-1:0]           cmd_bits,
   input  logic [15:0]                   cmd_len,
   input  logic                          cmd_readback,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [MAX_BITS-1:0]           rsp_bits,
   output logic                          spi_start,
   output logic [15:0]                   spi_bit_count,
   output logic [MAX_BITS-1:0]           spi_tx_bits,
   input  logic [MAX_BITS-1:0]           spi_rx_bits,
   input  logic                          spi_busy,
   input  logic                          spi_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [15:0]                   frames_done,
   output logic                          err_len,
   output logic                          err_timeout
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT_DONE, S_RESP, S_GAP
   } state_t;

   state_t state, state_nxt;

   logic [MAX_BITS-1:0] fifo_bits [FIFO_DEPTH];
   logic [15:0]         fifo_len  [FIFO_DEPTH];
   logic                fifo_rb   [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic                push, pop;
   logic                frm_readback;
   logic                len_bad;
   logic [GAP_W-1:0]    gap_cnt;
   logic                tmo_hit;

   assign cmd_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == S_IDLE) && (fifo_level != '0) && !spi_busy;
   assign len_bad   = (spi_bit_count == 16'd0) || (spi_bit_count > 16'(MAX_BITS));

   // Payload storage carries no reset; validity is tracked by fifo_level.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_bits[wr_ptr] <= cmd_bits;
         fifo_len[wr_ptr]  <= cmd_len;
         fifo_rb[wr_ptr]   <= cmd_readback;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      fifo_level <= fifo_level + 1'b1;
         else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      end
   end

   // Frame registers double as the SPI master drive; they only change on a
   // pop, so they stay stable from LOAD until the next LOAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_tx_bits   <= '0;
         spi_bit_count <= '0;
         frm_readback  <= 1'b0;
      end else if (pop) begin
         spi_tx_bits   <= fifo_bits[rd_ptr];
         spi_bit_count <= fifo_len[rd_ptr];
         frm_readback  <= fifo_rb[rd_ptr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_bits    <= '0;
         frames_done <= '0;
      end else if (state == S_WAIT_DONE && spi_done) begin
         rsp_bits    <= spi_rx_bits;
         frames_done <= frames_done + 16'd1;
      end
   end

   // Gap down-counter sits preloaded outside GAP and exits on terminal count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                gap_cnt <= GAP_W'(GAP_CYCLES);
      else if (state != S_GAP)   gap_cnt <= GAP_W'(GAP_CYCLES);
      else if (gap_cnt != '0)    gap_cnt <= gap_cnt - 1'b1;
   end

`ifdef SEQ_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      tmo_cnt <= '0;
      else if (state == S_START)                       tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
      else if (state == S_WAIT_DONE && tmo_cnt != '0)  tmo_cnt <= tmo_cnt - 1'b1;
   end

   // A done arriving on the terminal cycle still completes the frame.
   assign tmo_hit = (state == S_WAIT_DONE) && !spi_done && (tmo_cnt == '0);
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = |TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (pop) state_nxt = S_LOAD;
         S_LOAD:      state_nxt = len_bad ? S_IDLE : S_START;
         S_START:     state_nxt = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (spi_done)     state_nxt = frm_readback ? S_RESP : S_GAP;
            else if (tmo_hit) state_nxt = S_GAP;
         end
         S_RESP:      if (rsp_ready) state_nxt = S_GAP;
         S_GAP:       if (gap_cnt == '0) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      spi_start   = 1'b0;
      rsp_valid   = 1'b0;
      err_len     = 1'b0;
      err_timeout = 1'b0;
      case (state)
         S_LOAD:      err_len     = len_bad;
         S_START:     spi_start   = 1'b1;
         S_WAIT_DONE: err_timeout = tmo_hit;
         S_RESP:      rsp_valid   = 1'b1;
         default:     ;
      endcase
   end

endmodule

// File: tb/tb_awmf_frame_sequencer.sv
// Self-checking bench for awmf_frame_sequencer with a behavioural SPI master
// stub (done a programmable number of cycles after start).
module tb_awmf_frame_sequencer;

   localparam int MB  = 100;
   localparam int GAP = 4;
   localparam int TMO = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid, cmd_ready, cmd_readback;
   logic [MB-1:0] cmd_bits;
   logic [15:0]   cmd_len;
   logic          rsp_valid, rsp_ready;
   logic [MB-1:0] rsp_bits;
   logic          spi_start, spi_busy, spi_done;
   logic [15:0]   spi_bit_count;
   logic [MB-1:0] spi_tx_bits, spi_rx_bits;
   logic [2:0]    fifo_level;
   logic [15:0]   frames_done;
   logic          err_len, err_timeout;

   awmf_frame_sequencer #(
      .MAX_BITS(MB), .FIFO_DEPTH(4), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_bits(cmd_bits),
      .cmd_len(cmd_len), .cmd_readback(cmd_readback),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_bits(rsp_bits),
      .spi_start(spi_start), .spi_bit_count(spi_bit_count), .spi_tx_bits(spi_tx_bits),
      .spi_rx_bits(spi_rx_bits), .spi_busy(spi_busy), .spi_done(spi_done),
      .fifo_level(fifo_level), .frames_done(frames_done),
      .err_len(err_len), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc = cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- SPI master stub ----------------
   logic          stub_done = 1'b0, stub_busy = 1'b0, force_busy = 1'b0;
   logic          inj_done = 1'b0, stub_hang = 1'b0;
   logic [MB-1:0] stub_rx = '0;
   int            stub_delay = 1, stub_cnt = 0, n_done = 0, last_done = -1;

   assign spi_busy = stub_busy | force_busy;
   assign spi_done = stub_done | inj_done;

   always @(negedge clk) begin
      if (!rst_n) begin
         stub_done = 1'b0; stub_busy = 1'b0; stub_cnt = 0;
         spi_rx_bits = '0;
      end else begin
         if (stub_done) begin
            stub_done = 1'b0; stub_busy = 1'b0; spi_rx_bits = ~stub_rx;
         end
         if (spi_start) begin
            stub_busy = 1'b1;
            stub_cnt  = stub_hang ? 0 : stub_delay;
         end else if (stub_cnt > 0) begin
            stub_cnt = stub_cnt - 1;
            if (stub_cnt == 0) begin
               stub_done = 1'b1; spi_rx_bits = stub_rx;
               last_done = cyc;  n_done = n_done + 1;
            end
         end
      end
   end

   // ---------------- monitor ----------------
   int            n_start = 0, last_start = -1, n_err_len = 0, last_err = -1;
   int            n_tmo = 0, tmo_cyc = -1;
   logic          gap_chk = 1'b0;
   logic [MB-1:0] tx_log[$];

   always @(negedge clk) begin
      if (spi_start) begin
         n_start = n_start + 1;
         last_start = cyc;
         tx_log.push_back(spi_tx_bits);
         if (gap_chk && last_done >= 0)
            chk("done_to_start_gap", 128'(cyc - last_done >= GAP + 4), 128'(1));
      end
      if (err_len) begin n_err_len = n_err_len + 1; last_err = cyc; end
      if (err_timeout) begin n_tmo = n_tmo + 1; tmo_cyc = cyc; end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus helpers ----------------
   typedef struct {
      logic [MB-1:0] bits;
      logic [15:0]   len;
      logic          rb;
      logic [MB-1:0] rx;
      int            dly;
      logic          bad_len;
   } vec_t;

   vec_t vecs[6];
   int   exp_frames = 0;

   task automatic push(input logic [MB-1:0] b, input logic [15:0] l, input logic rb,
                       output int ncyc);
      int t = 0;
      cmd_bits = b; cmd_len = l; cmd_readback = rb; cmd_valid = 1'b1;
      while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
      chk("push_accept", 128'(cmd_ready), 128'(1));
      ncyc = cyc;
      @(negedge clk);
   endtask

   task automatic wait_rsp(output logic ok);
      int t = 0;
      while (!rsp_valid && t < 300) begin @(negedge clk); t++; end
      ok = rsp_valid;
      chk("rsp_valid_arrives", 128'(rsp_valid), 128'(1));
   endtask

   task automatic run_vec(input int i);
      int   n, s0, e0, d0, t;
      logic ok;
      s0 = n_start; e0 = n_err_len; d0 = n_done;
      stub_delay = vecs[i].dly; stub_rx = vecs[i].rx;
      push(vecs[i].bits, vecs[i].len, vecs[i].rb, n);
      cmd_valid = 1'b0;
      while (cyc < n + 3) @(negedge clk);
      if (vecs[i].bad_len) begin
         chk($sformatf("v%0d_err_len_count", i), 128'(n_err_len), 128'(e0 + 1));
         chk($sformatf("v%0d_err_len_cycle", i), 128'(last_err), 128'(n + 2));
         repeat (10) @(negedge clk);
         chk($sformatf("v%0d_no_start", i), 128'(n_start), 128'(s0));
      end else begin
         chk($sformatf("v%0d_start_latency", i), 128'(spi_start), 128'(1));
         chk($sformatf("v%0d_tx_bits", i), 128'(spi_tx_bits), 128'(vecs[i].bits));
         chk($sformatf("v%0d_bit_count", i), 128'(spi_bit_count), 128'(vecs[i].len));
         exp_frames++;
         if (vecs[i].rb) begin
            wait_rsp(ok);
            chk($sformatf("v%0d_rsp_latency", i), 128'(cyc), 128'(last_done + 1));
            chk($sformatf("v%0d_rsp_bits", i), 128'(rsp_bits), 128'(vecs[i].rx));
            rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
         end else begin
            t = 0;
            while (n_done == d0 && t < 300) begin @(negedge clk); t++; end
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_no_rsp", i), 128'(rsp_valid), 128'(0));
         end
         chk($sformatf("v%0d_single_start", i), 128'(n_start), 128'(s0 + 1));
      end
      repeat (8) @(negedge clk);
      chk($sformatf("v%0d_frames_done", i), 128'(frames_done), 128'(exp_frames));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"},   128'(cmd_ready), 128'(1));
      chk({tag, "_rsp_valid"},   128'(rsp_valid), 128'(0));
      chk({tag, "_rsp_bits"},    128'(rsp_bits), 128'(0));
      chk({tag, "_spi_start"},   128'(spi_start), 128'(0));
      chk({tag, "_bit_count"},   128'(spi_bit_count), 128'(0));
      chk({tag, "_tx_bits"},     128'(spi_tx_bits), 128'(0));
      chk({tag, "_fifo_level"},  128'(fifo_level), 128'(0));
      chk({tag, "_frames_done"}, 128'(frames_done), 128'(0));
      chk({tag, "_err_len"},     128'(err_len), 128'(0));
      chk({tag, "_err_timeout"}, 128'(err_timeout), 128'(0));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [MB-1:0] fill[5];
      int   n, s0, t, h, errs;
      logic ok;

      vecs[0] = '{100'hA5C3F0, 16'd24, 1'b1, 100'h123456, 30, 1'b0};
      vecs[1] = '{100'h0FF, 16'd0, 1'b1, 100'h0, 5, 1'b1};
      vecs[2] = '{100'h0FF, 16'd101, 1'b0, 100'h0, 5, 1'b1};
      vecs[3] = '{100'h1, 16'd1, 1'b0, 100'h0, 3, 1'b0};
      vecs[4] = '{{MB{1'b1}}, 16'd100, 1'b1, 100'hC0FFEE123456789ABCDEF0123, 5, 1'b0};
      vecs[5] = '{100'h3C, 16'd8, 1'b1, 100'h5A, 1, 1'b0};
      for (int k = 0; k < 5; k++) fill[k] = MB'(32'h1000 + 17 * k);

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_bits = '0; cmd_len = '0;
      cmd_readback = 1'b0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("in_reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("after_reset");

      for (int i = 0; i < 6; i++) run_vec(i);

      // Done while idle must be ignored.
      s0 = n_start;
      inj_done = 1'b1; @(negedge clk); inj_done = 1'b0;
      repeat (5) @(negedge clk);
      chk("stray_done_frames", 128'(frames_done), 128'(exp_frames));
      chk("stray_done_rsp", 128'(rsp_valid), 128'(0));
      chk("stray_done_start", 128'(n_start), 128'(s0));

      // FIFO fill with the master held busy, then drain in order.
      s0 = n_start; tx_log.delete(); last_done = -1; gap_chk = 1'b1;
      force_busy = 1'b1; stub_delay = 2;
      for (int k = 0; k < 4; k++) push(fill[k], 16'd8, 1'b0, n);
      cmd_valid = 1'b0;
      chk("full_cmd_ready", 128'(cmd_ready), 128'(0));
      chk("full_level", 128'(fifo_level), 128'(4));
      force_busy = 1'b0;
      push(fill[4], 16'd8, 1'b0, n);
      cmd_valid = 1'b0;
      t = 0;
      while (n_start < s0 + 5 && t < 500) begin @(negedge clk); t++; end
      repeat (15) @(negedge clk);
      chk("drain_starts", 128'(n_start), 128'(s0 + 5));
      for (int k = 0; k < 5; k++)
         chk($sformatf("drain_order_%0d", k),
             128'((k < tx_log.size()) ? tx_log[k] : '0), 128'(fill[k]));
      exp_frames += 5;
      chk("drain_frames_done", 128'(frames_done), 128'(exp_frames));
      chk("drain_level", 128'(fifo_level), 128'(0));

      // Response back-pressure for 50 cycles with a second frame queued.
      s0 = n_start; last_done = -1;
      stub_delay = 4; stub_rx = 100'hABCDE;
      push(100'h77, 16'd16, 1'b1, n);
      push(100'h88, 16'd16, 1'b1, n);
      cmd_valid = 1'b0;
      wait_rsp(ok);
      stub_rx = 100'h54321;
      errs = 0;
      for (int k = 0; k < 50; k++) begin
         if (rsp_valid !== 1'b1 || rsp_bits !== 100'hABCDE || n_start != s0 + 1) errs++;
         @(negedge clk);
      end
      chk("hold_stable_cycles_bad", 128'(errs), 128'(0));
      chk("hold_rsp_bits", 128'(rsp_bits), 128'(100'hABCDE));
      rsp_ready = 1'b1; h = cyc; @(negedge clk); rsp_ready = 1'b0;
      wait_rsp(ok);
      chk("hold_second_start_gap", 128'(last_start - h >= GAP + 4), 128'(1));
      chk("hold_second_rsp_bits", 128'(rsp_bits), 128'(100'h54321));
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      gap_chk = 1'b0;
      repeat (8) @(negedge clk);
      exp_frames += 2;
      chk("hold_frames_done", 128'(frames_done), 128'(exp_frames));

      // Master never completes; then reset in the middle with entries queued.
      s0 = n_start; stub_hang = 1'b1;
      push(100'h91, 16'd8, 1'b1, n);
      push(100'h92, 16'd8, 1'b1, n);
      push(100'h93, 16'd8, 1'b1, n);
      cmd_valid = 1'b0;
      t = 0;
      while (n_start == s0 && t < 50) begin @(negedge clk); t++; end
      repeat (80) @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
      chk("tmo_pulses", 128'(n_tmo), 128'(1));
      chk("tmo_cycle", 128'(tmo_cyc), 128'(last_start + TMO + 1));
`else
      chk("tmo_never", 128'(n_tmo), 128'(0));
`endif
      chk("hang_no_rsp", 128'(rsp_valid), 128'(0));
      chk("hang_single_start", 128'(n_start), 128'(s0 + 1));
      chk("hang_frames_done", 128'(frames_done), 128'(exp_frames));
      chk("hang_level", 128'(fifo_level), 128'(2));
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_reset");
      exp_frames = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; stub_hang = 1'b0;
      repeat (30) @(negedge clk);
      chk("post_reset_no_start", 128'(n_start), 128'(s0 + 1));
      chk("post_reset_level", 128'(fifo_level), 128'(0));
      chk("post_reset_rsp", 128'(rsp_valid), 128'(0));
      chk("post_reset_frames", 128'(frames_done), 128'(exp_frames));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
